deserializer: RTL and testbench
===============================

DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, giving the output word width in bits (legal range 2..64).
REQ-002 The module SHALL have port clk_i, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-003 The module SHALL have port arst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port data_i, input, 1 bit: the serial data bit.
REQ-005 The module SHALL have port data_val_i, input, 1 bit: qualifies data_i; a bit is accepted only on a rising edge where data_val_i is 1.
REQ-006 The module SHALL have port deser_data_o, output, DATA_W bits: the most recently completed parallel word.
REQ-007 The module SHALL have port deser_data_val_o, output, 1 bit: single-cycle strobe marking a newly completed word on deser_data_o.

Function
REQ-008 The module SHALL keep a shift register and a bit counter of width ceil(log2(DATA_W)), counting 0..DATA_W-1.
REQ-009 On each accepted bit, the module SHALL shift data_i into the shift register and increment the counter.
REQ-010 Cycles where data_val_i is 0 SHALL leave the shift register, the counter and deser_data_o unchanged, whatever the value on data_i; gaps of any length are legal.
REQ-011 Bit order SHALL be MSB-first by default: the first accepted bit of a word appears at deser_data_o[DATA_W-1] and the last at deser_data_o[0].
REQ-012 On the edge that accepts the DATA_W-th bit, the module SHALL register the complete word (including that bit) into deser_data_o and set deser_data_val_o to 1.
REQ-013 Latency SHALL be 1 cycle: deser_data_val_o and the new deser_data_o are visible immediately after the edge that accepts the final bit.
REQ-014 deser_data_val_o SHALL be high for exactly one cycle per completed word and low at all other times.
REQ-015 deser_data_o SHALL hold its value until the next word completes.
REQ-016 The counter SHALL wrap to 0 on word completion, so that the next accepted bit, even on the immediately following cycle, is bit 0 of a new word.
REQ-017 Back-to-back words SHALL be supported with no dead cycles: continuous valid input yields one strobe every DATA_W cycles.
REQ-018 There SHALL be no partial-word output: fewer than DATA_W accepted bits never assert deser_data_val_o.

Reset
REQ-019 When arst_n_i is 0, the module SHALL immediately, without waiting for a clock edge, clear the counter to 0, the shift register to 0, deser_data_o to 0 and deser_data_val_o to 0.
REQ-020 Reset asserted mid-word SHALL discard the partial word; the first bit accepted after release is bit 0 of a new word.
REQ-021 Reset deassertion is synchronised externally; the first rising edge with arst_n_i at 1 SHALL be able to accept a bit.

Configuration
REQ-022 When macro DESERIALIZER_LSB_FIRST_EN is defined, the module SHALL use LSB-first order: the first accepted bit appears at deser_data_o[0] and the DATA_W-th at deser_data_o[DATA_W-1].
REQ-023 When DESERIALIZER_LSB_FIRST_EN is not defined, the module SHALL use MSB-first order per REQ-011.
REQ-024 All other timing and behaviour SHALL be identical in both builds.

Verification (DATA_W=16)
REQ-025 The bench SHALL cover: reset, then 16 consecutive valid bits of 1 -> one strobe after the 16th edge, deser_data_o = 16'hFFFF.
REQ-026 The bench SHALL cover: after a word, 4 valid 0s, then 4 cycles with data_val_i=0 and data_i=1, then 12 valid 0s -> exactly one strobe with deser_data_o = 16'h0000, and no strobe during the gap.
REQ-027 The bench SHALL cover: MSB-first pattern 1,0,1,0,... over 16 valid bits -> deser_data_o = 16'hAAAA; with DESERIALIZER_LSB_FIRST_EN defined -> 16'h5555.
REQ-028 The bench SHALL cover: 48 continuous valid bits -> strobes exactly at bits 16, 32 and 48, each one cycle wide, with correct words.
REQ-029 The bench SHALL cover: 7 valid 1s, then arst_n_i pulsed low mid-cycle -> outputs 0 immediately; then 16 valid 0s -> a single strobe with 16'h0000, and no strobe before the 16th bit.
REQ-030 The bench SHALL cover: a single 1 followed by 15 valid 0s -> 16'h8000 by default, and 16'h0001 with DESERIALIZER_LSB_FIRST_EN defined.

Source files
------------

// File: rtl/deserializer.sv
// Serial-to-parallel converter: accepts qualified bits and emits a DATA_W-bit word with a one-cycle strobe.
// Bit order is MSB-first; define DESERIALIZER_LSB_FIRST_EN for LSB-first.
module deserializer #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              data_i,
  input  logic              data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic              deser_data_val_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_next;
  logic [CNT_W-1:0]  cnt_q;

  always_comb begin
    shift_next = shift_q;
`ifdef DESERIALIZER_LSB_FIRST_EN
    shift_next = {data_i, shift_q[DATA_W-1:1]};
`else
    shift_next = {shift_q[DATA_W-2:0], data_i};
`endif
  end

  // The completed word is taken from shift_next so the final bit lands in the same edge.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      shift_q          <= '0;
      cnt_q            <= '0;
      deser_data_o     <= '0;
      deser_data_val_o <= 1'b0;
    end else begin
      deser_data_val_o <= 1'b0;
      if (data_val_i) begin
        shift_q <= shift_next;
        if (cnt_q == CNT_LAST) begin
          cnt_q            <= '0;
          deser_data_o     <= shift_next;
          deser_data_val_o <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Directed self-checking bench for deserializer at DATA_W=16, covering both bit-order builds.
module tb_deserializer;

  localparam int unsigned W = 16;

  logic         clk_i = 1'b0;
  logic         arst_n_i;
  logic         data_i;
  logic         data_val_i;
  logic [W-1:0] deser_data_o;
  logic         deser_data_val_o;

  int checks = 0;
  int errors = 0;

  deserializer #(.DATA_W(W)) dut (
    .clk_i            (clk_i),
    .arst_n_i         (arst_n_i),
    .data_i           (data_i),
    .data_val_i       (data_val_i),
    .deser_data_o     (deser_data_o),
    .deser_data_val_o (deser_data_val_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after an edge, then sample just after the next edge.
  task automatic step(input logic v, input logic d, output logic stb);
    data_val_i = v;
    data_i     = d;
    @(posedge clk_i);
    #1;
    stb = deser_data_val_o;
  endtask

  function automatic logic [W-1:0] rev16(input logic [W-1:0] w);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = w[W-1-i];
    return r;
  endfunction

  // seq[15] is sent first; checks no early strobe, strobe on the 16th bit, and the word.
  task automatic feed_seq(input string tag, input logic [W-1:0] seq, input logic [W-1:0] exp);
    logic stb;
    int   early;
    early = 0;
    for (int i = 0; i < W; i++) begin
      step(1'b1, seq[W-1-i], stb);
      if (i < W - 1 && stb) early++;
    end
    check({tag, "_early_stb"}, 64'(early), 64'd0);
    check({tag, "_stb"}, 64'(stb), 64'd1);
    check({tag, "_data"}, 64'(deser_data_o), 64'(exp));
  endtask

  // Sequence sent so that the resulting word equals w in the active build.
  function automatic logic [W-1:0] order(input logic [W-1:0] w);
`ifdef DESERIALIZER_LSB_FIRST_EN
    return rev16(w);
`else
    return w;
`endif
  endfunction

`ifdef DESERIALIZER_LSB_FIRST_EN
  localparam logic [W-1:0] EXP_ALT    = 16'h5555;
  localparam logic [W-1:0] EXP_SINGLE = 16'h0001;
`else
  localparam logic [W-1:0] EXP_ALT    = 16'hAAAA;
  localparam logic [W-1:0] EXP_SINGLE = 16'h8000;
`endif

  initial begin
    logic         stb;
    int           cnt;
    logic [W-1:0] words [3];
    words[0] = 16'h1234;
    words[1] = 16'hBEEF;
    words[2] = 16'h0F0F;

    arst_n_i   = 1'b0;
    data_i     = 1'b0;
    data_val_i = 1'b0;
    #1;
    check("rst_data", 64'(deser_data_o), 64'd0);
    check("rst_val", 64'(deser_data_val_o), 64'd0);
    @(posedge clk_i);
    #1;
    arst_n_i = 1'b1;

    // 16 ones
    feed_seq("ones", 16'hFFFF, 16'hFFFF);
    step(1'b0, 1'b0, stb);
    check("ones_stb_width", 64'(stb), 64'd0);
    check("ones_hold", 64'(deser_data_o), 64'hFFFF);

    // 4 zeros, 4-cycle gap with data_i=1, 12 zeros
    cnt = 0;
    for (int i = 0; i < 4; i++) begin step(1'b1, 1'b0, stb); cnt += int'(stb); end
    for (int i = 0; i < 4; i++) begin step(1'b0, 1'b1, stb); cnt += int'(stb); end
    check("gap_hold", 64'(deser_data_o), 64'hFFFF);
    for (int i = 0; i < 11; i++) begin step(1'b1, 1'b0, stb); cnt += int'(stb); end
    check("gap_early_stb", 64'(cnt), 64'd0);
    step(1'b1, 1'b0, stb);
    check("gap_stb", 64'(stb), 64'd1);
    check("gap_data", 64'(deser_data_o), 64'h0000);

    // alternating 1,0,...
    feed_seq("alt", 16'hAAAA, EXP_ALT);

    // 48 continuous bits
    cnt = 0;
    for (int w = 0; w < 3; w++) begin
      logic [W-1:0] s;
      s = order(words[w]);
      for (int i = 0; i < W; i++) begin
        step(1'b1, s[W-1-i], stb);
        if (i < W - 1) cnt += int'(stb);
      end
      check($sformatf("b2b_stb%0d", w), 64'(stb), 64'd1);
      check($sformatf("b2b_data%0d", w), 64'(deser_data_o), 64'(words[w]));
    end
    check("b2b_extra_stb", 64'(cnt), 64'd0);
    step(1'b0, 1'b0, stb);
    check("b2b_stb_width", 64'(stb), 64'd0);

    // 7 ones then mid-cycle reset pulse
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, stb);
    data_val_i = 1'b0;
    #2;
    arst_n_i = 1'b0;
    #1;
    check("mrst_data", 64'(deser_data_o), 64'd0);
    check("mrst_val", 64'(deser_data_val_o), 64'd0);
    #1;
    arst_n_i = 1'b1;
    feed_seq("post_rst", 16'h0000, 16'h0000);

    // single 1 then 15 zeros
    feed_seq("single", 16'h8000, EXP_SINGLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule
